// File: rtl/mult_div_32b.sv
// mult_div_32b: iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// One shift-add or restoring shift-subtract step per clock; signs are fixed up in a final cycle.
module mult_div_32b #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        mthi,
    input  logic        mtlo,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t      state_q;
    logic [63:0] acc_q, acc_d;
    logic [31:0] a_q, a_d, b_q, b_d, hi_q, lo_q;
    logic [4:0]  cnt_q;
    logic        is_div_q, psign_q, rsign_q, dbz_q;
    logic        busy_q, done_q, dbz_out_q;
    logic [32:0] mul_sum, div_sh, div_diff;
    logic        div_ge;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix;
    // Divide: acc holds {rem, quot}; dividend bits stream in from the top of a_q.
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (b_q[0] ? {1'b0, a_q} : 33'd0);
        div_sh   = {acc_q[63:32], a_q[31]};
        div_diff = div_sh - {1'b0, b_q};
        div_ge   = div_sh >= {1'b0, b_q};
        acc_d    = is_div_q ? {(div_ge ? div_diff[31:0] : div_sh[31:0]), acc_q[30:0], div_ge}
                            : {mul_sum, acc_q[31:1]};
        a_d      = is_div_q ? {a_q[30:0], 1'b0} : a_q;
        b_d      = is_div_q ? b_q : {1'b0, b_q[31:1]};
        prod_fix = psign_q ? -acc_q : acc_q;
        quot_fix = psign_q ? -acc_q[31:0] : acc_q[31:0];
        rem_fix  = rsign_q ? -acc_q[63:32] : acc_q[63:32];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            psign_q   <= 1'b0;
            rsign_q   <= 1'b0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q    <= 1'b0;
                    dbz_out_q <= 1'b0;
                    if (start) begin
                        a_q      <= (op[0] && A[31]) ? -A : A;
                        b_q      <= (op[0] && B[31]) ? -B : B;
                        psign_q  <= op[0] & (A[31] ^ B[31]);
                        rsign_q  <= op[0] & A[31];
                        is_div_q <= op[1];
                        dbz_q    <= op[1] && (B == 32'd0);
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        if (mthi) hi_q <= A;
                        if (mtlo) lo_q <= A;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    a_q   <= a_d;
                    b_q   <= b_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(ITER - 1)) state_q <= FIX;
                end
                FIX: begin
                    hi_q      <= is_div_q ? rem_fix : prod_fix[63:32];
                    lo_q      <= is_div_q ? quot_fix : prod_fix[31:0];
                    done_q    <= 1'b1;
                    dbz_out_q <= dbz_q;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign HI          = hi_q;
    assign LO          = lo_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_out_q;
endmodule
